// File: rtl/note_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : note_scheduler
// Brief    : Fall-step timebase, chart ROM walker and spawn handshake for the
//            falling-note column datapath.
// Revision : 1.0 - initial release
// ============================================================================
module note_scheduler #(
  parameter int FALL_DIV    = 100000,
  parameter int SPAWN_DIV   = 125,
  parameter int NOTE_COUNT  = 176,
  parameter int ROM_AW      = 8,
  parameter int ROM_LAT     = 1,
  parameter int DRAIN_STEPS = 435
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic              fall_tick,
  output logic              spawn_valid,
  output logic [3:0]        spawn_mask,
  input  logic              spawn_ready,
  output logic              busy,
  output logic              done
);

  localparam int c_div_w    = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
  localparam int c_step_top = (SPAWN_DIV > DRAIN_STEPS) ? SPAWN_DIV : DRAIN_STEPS;
  localparam int c_step_w   = $clog2(c_step_top + 1);
  localparam int c_lat_w    = $clog2(ROM_LAT + 1);

  localparam logic [c_div_w-1:0]  c_div_last   = c_div_w'(FALL_DIV - 1);
  localparam logic [c_step_w-1:0] c_spawn_last = c_step_w'(SPAWN_DIV - 1);
  localparam logic [c_step_w-1:0] c_drain_last = c_step_w'(DRAIN_STEPS - 1);
  localparam logic [c_step_w-1:0] c_step_sat   = c_step_w'(c_step_top);
  localparam logic [c_lat_w-1:0]  c_lat_last   = c_lat_w'(ROM_LAT);
  localparam logic [ROM_AW-1:0]   c_addr_last  = ROM_AW'(NOTE_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_OFFER = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_div_w-1:0]  r_div, w_div_nxt;
  logic                r_tick, w_tick_nxt;
  logic [c_step_w-1:0] r_step, w_step_nxt;
  logic [c_lat_w-1:0]  r_lat, w_lat_nxt;
  logic [ROM_AW-1:0]   r_addr, w_addr_nxt;
  logic [3:0]          r_mask, w_mask_nxt;
  logic                r_done, w_done_nxt;

  // Pause freezes the whole timebase (including a pending tick) and only masks the output.
  logic w_tick;
  logic w_run;
  assign w_tick = r_tick & ~pause;
  assign w_run  = (r_state != S_IDLE) & ~pause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_tick  <= 1'b0;
      r_step  <= '0;
      r_lat   <= '0;
      r_addr  <= '0;
      r_mask  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_tick  <= w_tick_nxt;
      r_step  <= w_step_nxt;
      r_lat   <= w_lat_nxt;
      r_addr  <= w_addr_nxt;
      r_mask  <= w_mask_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_tick_nxt  = r_tick;
    w_step_nxt  = r_step;
    w_lat_nxt   = r_lat;
    w_addr_nxt  = r_addr;
    w_mask_nxt  = r_mask;
    w_done_nxt  = 1'b0;

    // The tick register is high during the cycle in which div_cnt sits at its terminal value.
    if (w_run) begin
      w_div_nxt  = (r_div == c_div_last) ? '0 : r_div + 1'b1;
      w_tick_nxt = (w_div_nxt == c_div_last);
    end
    if (w_tick && (r_step != c_step_sat)) begin
      w_step_nxt = r_step + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_div_nxt   = '0;
          w_step_nxt  = '0;
          w_addr_nxt  = '0;
        end
      end
      S_FETCH: begin
        if (r_lat == c_lat_last) begin
          w_mask_nxt  = rom_data;
          w_lat_nxt   = '0;
          w_state_nxt = S_OFFER;
        end else begin
          w_lat_nxt = r_lat + 1'b1;
        end
      end
      S_OFFER: begin
        if (spawn_ready) begin
          w_step_nxt  = '0;
          w_addr_nxt  = r_addr + 1'b1;
          w_state_nxt = (r_addr == c_addr_last) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (w_tick && (r_step == c_spawn_last)) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (w_tick && (r_step == c_drain_last)) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_done_nxt  = 1'b0;
    end
    // Every entry into IDLE leaves the counters, address and mask at zero.
    if (w_state_nxt == S_IDLE) begin
      w_div_nxt  = '0;
      w_tick_nxt = 1'b0;
      w_step_nxt = '0;
      w_lat_nxt  = '0;
      w_addr_nxt = '0;
      w_mask_nxt = '0;
    end
  end

  assign rom_addr    = r_addr;
  assign fall_tick   = w_tick;
  assign spawn_valid = (r_state == S_OFFER);
  assign spawn_mask  = r_mask;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_note_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_scheduler
// Brief    : Directed self-checking bench for note_scheduler (small parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_scheduler;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic       abort;
  logic [7:0] rom_addr;
  logic [3:0] rom_data;
  logic       fall_tick;
  logic       spawn_valid;
  logic [3:0] spawn_mask;
  logic       spawn_ready;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  logic [3:0] rows [0:3];

  note_scheduler #(
    .FALL_DIV   (4),
    .SPAWN_DIV  (3),
    .NOTE_COUNT (3),
    .ROM_AW     (8),
    .ROM_LAT    (1),
    .DRAIN_STEPS(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .fall_tick  (fall_tick),
    .spawn_valid(spawn_valid),
    .spawn_mask (spawn_mask),
    .spawn_ready(spawn_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency chart ROM holding rows 1, 0, F
  always @(posedge clk) begin
    if (rom_addr < 8'd4) rom_data <= rows[rom_addr[1:0]];
    else                 rom_data <= 4'h0;
  end

  // Leaves the bench at the falling edge of cycle 0, the first cycle after start is sampled.
  task automatic run_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clean_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    spawn_ready = 1'b1;
    pause = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (spawn_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", spawn_valid); end
    checks++; if (fall_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", fall_tick); end
    checks++; if (rom_addr !== 8'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
    checks++; if (spawn_mask !== 4'h0) begin failures++; $display("FAIL reset_mask got=%h exp=0", spawn_mask); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  // Offers at 2, 14, 26; ticks at cycles 3 mod 4; the second drain tick (31) registers done at 32.
  task automatic test_playback();
    logic       exp_v;
    logic [3:0] exp_mask;
    logic [7:0] exp_addr;
    run_start();
    for (int c = 0; c < 36; c++) begin
      if (c > 0) @(negedge clk);
      exp_v = (c == 2) || (c == 14) || (c == 26);
      checks++; if (spawn_valid !== exp_v) begin failures++; $display("FAIL play_valid c=%0d got=%b exp=%b", c, spawn_valid, exp_v); end
      if (exp_v) begin
        exp_mask = (c == 2) ? 4'h1 : ((c == 14) ? 4'h0 : 4'hF);
        exp_addr = 8'((c - 2) / 12);
        checks++; if (spawn_mask !== exp_mask) begin failures++; $display("FAIL play_mask c=%0d got=%h exp=%h", c, spawn_mask, exp_mask); end
        checks++; if (rom_addr !== exp_addr) begin failures++; $display("FAIL play_addr c=%0d got=%0d exp=%0d", c, rom_addr, exp_addr); end
      end
      checks++; if (fall_tick !== ((c % 4 == 3) && (c <= 31))) begin failures++; $display("FAIL play_tick c=%0d got=%b", c, fall_tick); end
      checks++; if (done !== (c == 32)) begin failures++; $display("FAIL play_done c=%0d got=%b", c, done); end
      checks++; if (busy !== (c < 32)) begin failures++; $display("FAIL play_busy c=%0d got=%b", c, busy); end
    end
  endtask

  // Ready low across cycles 14..22 and rising mid-23: accept in cycle 23, next offer at 38, done at 44.
  task automatic test_stall();
    logic       exp_v;
    logic [3:0] exp_mask;
    run_start();
    for (int c = 0; c < 48; c++) begin
      if (c > 0) @(negedge clk);
      exp_v = (c == 2) || ((c >= 14) && (c <= 23)) || (c == 38);
      checks++; if (spawn_valid !== exp_v) begin failures++; $display("FAIL stall_valid c=%0d got=%b exp=%b", c, spawn_valid, exp_v); end
      if (exp_v) begin
        exp_mask = (c == 2) ? 4'h1 : ((c == 38) ? 4'hF : 4'h0);
        checks++; if (spawn_mask !== exp_mask) begin failures++; $display("FAIL stall_mask c=%0d got=%h exp=%h", c, spawn_mask, exp_mask); end
      end
      checks++; if (fall_tick !== ((c % 4 == 3) && (c <= 43))) begin failures++; $display("FAIL stall_tick c=%0d got=%b", c, fall_tick); end
      checks++; if (done !== (c == 44)) begin failures++; $display("FAIL stall_done c=%0d got=%b", c, done); end
      if (c == 13) spawn_ready = 1'b0;
      if (c == 23) spawn_ready = 1'b1;
    end
  endtask

  // Pause from mid-4 to mid-24 shifts the tick due at 7 to 27; FETCH at 32, offer of row 1 at 34.
  task automatic test_pause();
    logic exp_v;
    run_start();
    for (int c = 0; c < 36; c++) begin
      if (c > 0) @(negedge clk);
      exp_v = (c == 2) || (c >= 34);
      checks++; if (spawn_valid !== exp_v) begin failures++; $display("FAIL pause_valid c=%0d got=%b exp=%b", c, spawn_valid, exp_v); end
      checks++; if (fall_tick !== ((c == 3) || ((c >= 27) && (c % 4 == 3)))) begin failures++; $display("FAIL pause_tick c=%0d got=%b", c, fall_tick); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL pause_done c=%0d got=%b exp=0", c, done); end
      if (c >= 34) begin
        checks++; if (spawn_mask !== 4'h0) begin failures++; $display("FAIL pause_mask c=%0d got=%h exp=0", c, spawn_mask); end
      end
      if (c == 4) pause = 1'b1;
      if (c == 24) pause = 1'b0;
      if (c == 33) spawn_ready = 1'b0;
    end
    clean_abort();
  endtask

  // Abort while the second row (address 1) is held in OFFER, then replay from row 0.
  task automatic test_abort();
    logic exp_v;
    run_start();
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      exp_v = (c == 2) || ((c >= 14) && (c <= 16));
      checks++; if (spawn_valid !== exp_v) begin failures++; $display("FAIL abort_valid c=%0d got=%b exp=%b", c, spawn_valid, exp_v); end
      checks++; if (busy !== (c <= 16)) begin failures++; $display("FAIL abort_busy c=%0d got=%b", c, busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done c=%0d got=%b exp=0", c, done); end
      checks++; if (fall_tick !== ((c % 4 == 3) && (c <= 15))) begin failures++; $display("FAIL abort_tick c=%0d got=%b", c, fall_tick); end
      if (c >= 14) begin
        checks++; if (rom_addr !== ((c <= 16) ? 8'd1 : 8'd0)) begin failures++; $display("FAIL abort_addr c=%0d got=%0d", c, rom_addr); end
      end
      if (c == 13) spawn_ready = 1'b0;
      if (c == 16) abort = 1'b1;
      if (c == 17) abort = 1'b0;
    end
    spawn_ready = 1'b1;
    run_start();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (spawn_valid !== (c == 2)) begin failures++; $display("FAIL replay_valid c=%0d got=%b", c, spawn_valid); end
      if (c == 2) begin
        checks++; if (spawn_mask !== 4'h1) begin failures++; $display("FAIL replay_mask got=%h exp=1", spawn_mask); end
        checks++; if (rom_addr !== 8'd0) begin failures++; $display("FAIL replay_addr got=%0d exp=0", rom_addr); end
      end
    end
    clean_abort();
  endtask

  task automatic test_start_abort();
    logic exp_v;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL both_busy c=%0d got=%b exp=0", c, busy); end
      checks++; if (spawn_valid !== 1'b0) begin failures++; $display("FAIL both_valid c=%0d got=%b exp=0", c, spawn_valid); end
    end
    // A start pulse in RUN must not restart playback (a restart would offer row 0 at cycle 8).
    run_start();
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      exp_v = (c == 2) || (c == 14);
      checks++; if (spawn_valid !== exp_v) begin failures++; $display("FAIL runstart_valid c=%0d got=%b exp=%b", c, spawn_valid, exp_v); end
      if (c == 14) begin
        checks++; if (spawn_mask !== 4'h0) begin failures++; $display("FAIL runstart_mask got=%h exp=0", spawn_mask); end
        checks++; if (rom_addr !== 8'd1) begin failures++; $display("FAIL runstart_addr got=%0d exp=1", rom_addr); end
      end
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
    end
    clean_abort();
  endtask

  // Cycle 31 is the final drain tick; rst lands between edges, before done can register.
  task automatic test_async_rst();
    run_start();
    for (int c = 1; c < 32; c++) @(negedge clk);
    checks++; if (fall_tick !== 1'b1) begin failures++; $display("FAIL arst_pre_tick got=%b exp=1", fall_tick); end
    checks++; if (rom_addr !== 8'd3) begin failures++; $display("FAIL arst_pre_addr got=%0d exp=3", rom_addr); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
    checks++; if (fall_tick !== 1'b0) begin failures++; $display("FAIL arst_tick got=%b exp=0", fall_tick); end
    checks++; if (spawn_mask !== 4'h0) begin failures++; $display("FAIL arst_mask got=%h exp=0", spawn_mask); end
    checks++; if (rom_addr !== 8'd0) begin failures++; $display("FAIL arst_addr got=%0d exp=0", rom_addr); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL arst_done got=%b exp=0", done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL arst_post_done c=%0d got=%b exp=0", c, done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_post_busy c=%0d got=%b exp=0", c, busy); end
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rows[0]     = 4'h1;
    rows[1]     = 4'h0;
    rows[2]     = 4'hF;
    rows[3]     = 4'h0;
    rst         = 1'b1;
    start       = 1'b0;
    pause       = 1'b0;
    abort       = 1'b0;
    spawn_ready = 1'b1;
    test_reset();
    test_playback();
    test_stall();
    test_pause();
    test_abort();
    test_start_abort();
    test_async_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
